// File: rtl/mips_pkg.sv
// Shared MIPS32 control definitions: state encoding, opcodes and datapath select codes.
// States 10/11 exist only when ADDI_SUPPORT_EN is defined.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC      = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
`ifdef ADDI_SUPPORT_EN
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
`endif
        INICIO    = 4'd12
    } estado_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_CONST4  = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // fetch_commit marks the strobes that only fire once the instruction fetch completes.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       fetch_commit;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/unidad_control_multiciclo_if.sv
// Control/datapath bundle of the multicycle control unit.
// master = control unit, slave = datapath side.
interface unidad_control_multiciclo_if #(
    parameter int OPC_W = 6
);
    logic [OPC_W-1:0] opcode;
    logic             cero;
    logic             mem_listo;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic [1:0]       PCSource;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             opcode_ilegal;
    logic [3:0]       estado;

    modport master (
        input  opcode, mem_listo,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, opcode_ilegal, estado
    );

    // The zero flag only reaches the PC through PCWriteCond in the datapath.
    modport slave (
        output opcode, cero, mem_listo,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
               ALUOp, opcode_ilegal, estado
    );
endinterface

// File: rtl/decodificador_estado.sv
// Purely combinational state -> control-word decoder of the multicycle control unit.
// ADDI_SUPPORT_EN adds the decode of ADDI_EXEC/ADDI_WB.
module decodificador_estado
    import mips_pkg::*;
(
    input  estado_t i_estado,
    output ctrl_t   o_ctrl
);

    always_comb begin
        o_ctrl = CTRL_NONE;
        case (i_estado)
            FETCH: begin
                o_ctrl.mem_read     = 1'b1;
                o_ctrl.fetch_commit = 1'b1;
                o_ctrl.alu_src_b    = SRCB_CONST4;
                o_ctrl.alu_op       = ALUOP_ADD;
                o_ctrl.pc_source    = PCSRC_ALU;
            end
            DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMM_SH2;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                o_ctrl.iord      = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REGB;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = SRCB_REGB;
                o_ctrl.alu_op        = ALUOP_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef ADDI_SUPPORT_EN
            ADDI_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
`endif
            default: o_ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle main control FSM for the MIPS32 core: state register, next-state logic, strobes.
// Optional: ADDI_SUPPORT_EN enables the addi path (ADDI_EXEC/ADDI_WB); otherwise addi is illegal.
module unidad_control_multiciclo
    import mips_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic                         clk,
    input  logic                         reset_n,
    unidad_control_multiciclo_if.master  bus
);

    estado_t r_estado;
    estado_t w_estado_sig;
    logic    w_ilegal;
    logic    w_commit;
    ctrl_t   w_ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= INICIO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // The IR holds the opcode stable, so MEM_ADDR can re-read it to pick lw vs sw.
    always_comb begin
        w_estado_sig = r_estado;
        w_ilegal     = 1'b0;
        case (r_estado)
            INICIO:    w_estado_sig = FETCH;
            FETCH:     if (bus.mem_listo) w_estado_sig = DECODE;
            DECODE: begin
                if (bus.opcode == OPC_W'(OP_RTYPE)) begin
                    w_estado_sig = EXEC;
                end else if (bus.opcode == OPC_W'(OP_LW) || bus.opcode == OPC_W'(OP_SW)) begin
                    w_estado_sig = MEM_ADDR;
                end else if (bus.opcode == OPC_W'(OP_BEQ)) begin
                    w_estado_sig = BRANCH;
                end else if (bus.opcode == OPC_W'(OP_J)) begin
                    w_estado_sig = JUMP;
`ifdef ADDI_SUPPORT_EN
                end else if (bus.opcode == OPC_W'(OP_ADDI)) begin
                    w_estado_sig = ADDI_EXEC;
`endif
                end else begin
                    w_estado_sig = FETCH;
                    w_ilegal     = 1'b1;
                end
            end
            MEM_ADDR:  w_estado_sig = (bus.opcode == OPC_W'(OP_SW)) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (bus.mem_listo) w_estado_sig = MEM_WB;
            MEM_WB:    w_estado_sig = FETCH;
            MEM_WRITE: if (bus.mem_listo) w_estado_sig = FETCH;
            EXEC:      w_estado_sig = R_WB;
            R_WB:      w_estado_sig = FETCH;
            BRANCH:    w_estado_sig = FETCH;
            JUMP:      w_estado_sig = FETCH;
`ifdef ADDI_SUPPORT_EN
            ADDI_EXEC: w_estado_sig = ADDI_WB;
            ADDI_WB:   w_estado_sig = FETCH;
`endif
            default:   w_estado_sig = FETCH;
        endcase
    end

    decodificador_estado u_decodificador_estado (
        .i_estado (r_estado),
        .o_ctrl   (w_ctrl)
    );

    // IR and PC only latch the fetched word in the cycle memory delivers it.
    assign w_commit = w_ctrl.fetch_commit & bus.mem_listo;

    assign bus.PCWrite       = w_ctrl.pc_write | w_commit;
    assign bus.IRWrite       = w_commit;
    assign bus.PCWriteCond   = w_ctrl.pc_write_cond;
    assign bus.IorD          = w_ctrl.iord;
    assign bus.MemRead       = w_ctrl.mem_read;
    assign bus.MemWrite      = w_ctrl.mem_write;
    assign bus.MemtoReg      = w_ctrl.mem_to_reg;
    assign bus.ALUSrcA       = w_ctrl.alu_src_a;
    assign bus.RegWrite      = w_ctrl.reg_write;
    assign bus.RegDst        = w_ctrl.reg_dst;
    assign bus.PCSource      = w_ctrl.pc_source;
    assign bus.ALUSrcB       = w_ctrl.alu_src_b;
    assign bus.ALUOp         = w_ctrl.alu_op;
    assign bus.opcode_ilegal = w_ilegal;
    assign bus.estado        = r_estado;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Self-checking bench for unidad_control_multiciclo: per-cycle state and control-word checks.
module tb_unidad_control_multiciclo;

`ifdef ADDI_SUPPORT_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    unidad_control_multiciclo_if #(.OPC_W(6)) bus ();

    unidad_control_multiciclo #(.OPC_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [5:0]  opc;
        logic [3:0]  len;
        logic [31:0] st;   // nibble k = expected state in cycle k
        logic [7:0]  ml;   // bit k = mem_listo in cycle k
    } vec_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] cw;
    } exp_t;

    vec_t vt [11];
    exp_t sb [$];
    int   nvec = 0;
    int   nerr = 0;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
    //  PCSource[1:0],ALUSrcB[1:0],ALUOp[1:0],opcode_ilegal}
    function automatic logic [16:0] exp_cw(logic [3:0] s, logic ml, logic [5:0] opc);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, il;
        logic [1:0] pcs, srcb, aop;
        {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, il} = '0;
        pcs = 2'b00; srcb = 2'b00; aop = 2'b00;
        case (s)
            4'd0: begin mr = 1; srcb = 2'b01; irw = ml; pcw = ml; end
            4'd1: begin
                srcb = 2'b11;
                il = !((opc inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02}) || (ADDI_EN && opc == 6'h08));
            end
            4'd2: begin srca = 1; srcb = 2'b10; end
            4'd3: begin mr = 1; iord = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin iord = 1; mw = 1; end
            4'd6: begin srca = 1; aop = 2'b10; end
            4'd7: begin rd = 1; rw = 1; end
            4'd8: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9: begin pcw = 1; pcs = 2'b10; end
            4'd10: if (ADDI_EN) begin srca = 1; srcb = 2'b10; end
            4'd11: if (ADDI_EN) rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, pcs, srcb, aop, il};
    endfunction

    function automatic logic [16:0] dut_cw();
        return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
                bus.PCSource, bus.ALUSrcB, bus.ALUOp, bus.opcode_ilegal};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin
            nerr++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    initial begin
        vt[0]  = '{opc: 6'h00, len: 4'd4, st: 32'h0000_7610, ml: 8'hFF};  // R-type
        vt[1]  = '{opc: 6'h00, len: 4'd4, st: 32'h0000_7610, ml: 8'h01};  // mem_listo ignored
        vt[2]  = '{opc: 6'h23, len: 4'd5, st: 32'h0004_3210, ml: 8'hFF};  // lw
        vt[3]  = '{opc: 6'h23, len: 4'd8, st: 32'h4333_3210, ml: 8'hC7};  // lw, 3 waits
        vt[4]  = '{opc: 6'h2B, len: 4'd4, st: 32'h0000_5210, ml: 8'hFF};  // sw
        vt[5]  = '{opc: 6'h2B, len: 4'd5, st: 32'h0005_5210, ml: 8'h17};  // sw, 1 wait
        vt[6]  = '{opc: 6'h04, len: 4'd3, st: 32'h0000_0810, ml: 8'hFF};  // beq
        vt[7]  = '{opc: 6'h02, len: 4'd3, st: 32'h0000_0910, ml: 8'hFF};  // j
        vt[8]  = '{opc: 6'h3F, len: 4'd2, st: 32'h0000_0010, ml: 8'hFF};  // illegal
        vt[9]  = '{opc: 6'h00, len: 4'd5, st: 32'h0007_6100, ml: 8'h1E};  // fetch wait
        if (ADDI_EN) vt[10] = '{opc: 6'h08, len: 4'd4, st: 32'h0000_BA10, ml: 8'hFF};
        else         vt[10] = '{opc: 6'h08, len: 4'd2, st: 32'h0000_0010, ml: 8'hFF};

        bus.opcode = 6'h00;
        bus.cero = 1'b0;
        bus.mem_listo = 1'b1;

        // Reset: held, then released between edges.
        repeat (2) @(negedge clk);
        check("reset_estado", 32'(bus.estado), 32'd12);
        check("reset_outputs", 32'(dut_cw()), 32'd0);
        reset_n = 1'b1;
        #1;
        check("inicio_estado", 32'(bus.estado), 32'd12);
        check("inicio_outputs", 32'(dut_cw()), 32'd0);

        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < int'(vt[v].len); k++) begin
                exp_t e;
                exp_t g;
                @(negedge clk);
                bus.opcode = vt[v].opc;
                bus.mem_listo = vt[v].ml[k];
                e.st = vt[v].st[k*4 +: 4];
                e.cw = exp_cw(e.st, vt[v].ml[k], vt[v].opc);
                sb.push_back(e);
                #1;
                g = sb.pop_front();
                check($sformatf("vec%0d_cyc%0d", v, k),
                      {11'd0, bus.estado, dut_cw()}, {11'd0, g.st, g.cw});
            end
        end

        // Reset asserted mid-store: MemWrite must drop immediately.
        @(negedge clk); bus.opcode = 6'h2B; bus.mem_listo = 1'b1;
        @(negedge clk); bus.mem_listo = 1'b1;
        @(negedge clk); bus.mem_listo = 1'b0;
        @(negedge clk); bus.mem_listo = 1'b0;
        #1;
        check("sw_wait_estado", 32'(bus.estado), 32'd5);
        check("sw_wait_memwrite", 32'(bus.MemWrite), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("rst_estado", 32'(bus.estado), 32'd12);
        bus.mem_listo = 1'b1;
        @(negedge clk);
        check("rst_hold_outputs", 32'(dut_cw()), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rerelease_fetch", {11'd0, bus.estado, dut_cw()},
              {11'd0, 4'd0, exp_cw(4'd0, 1'b1, 6'h2B)});
        @(negedge clk);
        check("rerelease_decode", 32'(bus.estado), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
